// File: rtl/image_ram_ctrl.sv
// image_ram_ctrl: single-port image RAM with registered read pipeline,
// auto-incrementing pointer and a post-reset clear sweep.
module image_ram_ctrl #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            control_signal,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  addr_mode,
  input  logic                  ptr_load,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out_port,
  output logic                  rd_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ptr
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic {RUN, CLEAR} state_e;
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, ptr_q, ptr_d, eff, waddr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, mid_d_q, dout_q, dout_d, wdata, last_d;
  logic acc, wr_en, rv_q, rv_d, mid_v_q, mid_v_d, rdv_q, rdv_d, last_v;
  always_comb begin
    busy    = state_q == CLEAR;
    acc     = control_signal[1] & ~busy;
    // a pointer load in the same cycle overrides the pointer as address source
    eff     = (addr_mode & ~ptr_load) ? ptr_q : address;
    wr_en   = busy | (acc & control_signal[0]);
    waddr   = busy ? cnt_q : eff;
    wdata   = busy ? CLEAR_VALUE : data_in;
    cnt_d   = busy ? cnt_q + 1'b1 : cnt_q;
    state_d = (busy && cnt_q == '1) ? RUN : state_q;
    ptr_d   = busy ? ptr_q : (acc & addr_mode) ? eff + 1'b1 : ptr_load ? address : ptr_q;
    rv_d    = acc & ~control_signal[0];
    mid_v_d = rv_q;
    last_v  = (READ_LATENCY == 2) ? mid_v_q : rv_q;
    last_d  = (READ_LATENCY == 2) ? mid_d_q : rdata_q;
    rdv_d   = last_v;
    dout_d  = last_v ? last_d : dout_q;
  end
  // RAM array and its data path carry no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
    rdata_q <= mem[eff];
    mid_d_q <= rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
      ptr_q   <= '0;
      rv_q    <= 1'b0;
      mid_v_q <= 1'b0;
      rdv_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rv_q    <= rv_d;
      mid_v_q <= mid_v_d;
      rdv_q   <= rdv_d;
      dout_q  <= dout_d;
    end
  end
  assign data_out_port = dout_q;
  assign rd_valid      = rdv_q;
  assign ptr           = ptr_q;
endmodule
